apb_sram_ws: RTL and testbench
==============================

APB_SRAM_WS -- requirements
Module: apb_sram_ws

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, word-address bits; memory depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, window base; bits [ADDR_W+1:0] are zero.
REQ-003 SHALL have parameter RD_WAIT, default 2, range 0..15, read wait states.
REQ-004 SHALL have parameter WR_WAIT, default 1, range 0..15, write wait states.
REQ-005 SHALL have parameter PROT_WORDS, default 256, count of write-protected low words (used only under REQ-026).
REQ-006 SHALL have the following ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_paddr  in  32  byte address.
- in_psel, in_penable, in_pwrite  in  1 each  APB control.
- in_pprot  in  3  protection; bit0=1 means privileged.
- in_pwdata  in  32  write data.
- in_pstrb  in  4  byte strobes.
- in_pready  out  1  transfer complete, registered.
- in_prdata  out  32  read data, registered.
- in_pslverr  out  1  error, registered.

Function
REQ-007 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-008 SHALL treat the first cycle with psel=1, penable=1 in IDLE as access cycle T0 and latch addr, pwrite, pwdata, pstrb and pprot.
REQ-009 SHALL set N=RD_WAIT for reads and N=WR_WAIT for writes; N=0 goes IDLE->RESP, otherwise IDLE->WAIT with counter=N-1.
REQ-010 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge after counter==0.
REQ-011 SHALL assert in_pready exactly in cycle T0+N+1 (RESP) for one cycle, then return to IDLE unconditionally.
REQ-012 SHALL define a hit as paddr[31:ADDR_W+2]==BASE_ADDR[31:ADDR_W+2]; the word index is paddr[ADDR_W+1:2], and paddr[1:0] is ignored.
REQ-013 SHALL, for a read hit, load in_prdata from memory on the edge entering RESP, with pslverr=0.
REQ-014 SHALL, for a write hit, update only the strobed bytes on the edge ending RESP; pstrb=0 is a legal no-op that completes with pslverr=0.
REQ-015 SHALL, for a miss, leave memory unchanged, set prdata=0 and pslverr=1 in RESP, using the same latency as a hit.
REQ-016 SHALL drive in_prdata=0 and in_pslverr=0 in every cycle other than RESP.
REQ-017 SHALL, if psel drops during WAIT, return to IDLE with no pready, no write and no error.
REQ-018 SHALL ignore psel and penable while in WAIT and RESP, except as stated in REQ-017.
REQ-019 SHALL accept back-to-back transfers: a new T0 may occur in the first IDLE cycle after RESP.
REQ-020 SHALL tie qspi_sck=0 and qspi_ce_n=1, and leave qspi_dio[3:0] high-impedance; the block has no QSPI activity.

Reset
REQ-021 SHALL, while reset_n=0, force state IDLE, counter 0, pready 0, prdata 0 and pslverr 0, asynchronously.
REQ-022 SHALL, on reset mid-transfer, discard the pending write; memory contents are unaffected by reset.
REQ-023 SHALL leave the first cycle after reset release in IDLE, ready for T0.

Configuration
REQ-024 SHALL use the macro APB_SRAM_WS_WPROT_EN.
REQ-025 SHALL, with the macro undefined, ignore in_pprot and PROT_WORDS.
REQ-026 SHALL, with the macro defined, block a write hit whose word index is < PROT_WORDS and whose pprot[0]=0: memory is unchanged and pslverr=1 in RESP.
REQ-027 SHALL, with the macro defined, leave reads and privileged writes unaffected.

Verification
REQ-028 Defaults; write 0xDEADBEEF to 0x8000_0400 with strobe 0xF, T0 at cycle 10 -> pready at cycle 12, pslverr=0; read of the same address -> pready at T0+3, prdata=0xDEADBEEF.
REQ-029 Write 0x1122_3344 with strobe 0x5 over 0xDEADBEEF -> a subsequent read returns 0xDE22_BE44.
REQ-030 Read 0x9000_0000 -> pready at T0+3, pslverr=1, prdata=0; a write there leaves memory unchanged.
REQ-031 RD_WAIT=0 and WR_WAIT=0 -> pready at T0+1; eight back-to-back read/write pairs all complete with correct data.
REQ-032 reset_n=0 asserted during WAIT of a write to 0x8000_0010 -> pready never asserted and old data retained; the next read works.
REQ-033 With APB_SRAM_WS_WPROT_EN: write to word 5 with pprot=0 -> pslverr=1 and data unchanged; the same write with pprot=1 -> pslverr=0 and data updated.

Source files
------------

// File: rtl/apb_sram_ws.sv
// APB slave in front of a 2^ADDR_W x 32 SRAM with programmable read/write wait states.
// Optional low-word write protection for unprivileged masters: define APB_SRAM_WS_WPROT_EN.
module apb_sram_ws #(
  parameter int          ADDR_W     = 20,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_WAIT    = 2,
  parameter int          WR_WAIT    = 1,
  parameter int          PROT_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic        in_pwrite,
  input  logic [2:0]  in_pprot,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        qspi_sck,
  output logic        qspi_ce_n,
  inout  wire  [3:0]  qspi_dio,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] RD_N = 4'(RD_WAIT);
  localparam logic [3:0] WR_N = 4'(WR_WAIT);

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              hit_q;
  logic              wr_q;
  logic              blk_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;

  // The QSPI pins are present only for pin compatibility and stay inactive.
  assign qspi_sck  = 1'b0;
  assign qspi_ce_n = 1'b1;
  assign qspi_dio  = 4'bzzzz;
  assign dbg_state = state;

  logic              start;
  logic [ADDR_W-1:0] idx_now;
  logic              hit_now;
  logic              blk_now;
  logic [3:0]        n_now;

  assign start   = in_psel & in_penable;
  assign idx_now = in_paddr[ADDR_W+1:2];
  assign hit_now = (in_paddr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign n_now   = in_pwrite ? WR_N : RD_N;

`ifdef APB_SRAM_WS_WPROT_EN
  localparam logic [31:0] PROT_LIM = 32'(PROT_WORDS);
  // Unprivileged writes into the low protected words are refused.
  assign blk_now = in_pwrite & ~in_pprot[0] & hit_now & (32'(idx_now) < PROT_LIM);
  logic unused_bits;
  assign unused_bits = ^{in_paddr[1:0], in_pprot[2:1]};
`else
  assign blk_now = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{in_paddr[1:0], in_pprot};
`endif

  // When RESP is entered straight from IDLE the latches are not loaded yet,
  // so the response is computed from the live bus instead.
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_hit;
  logic              acc_wr;
  logic              acc_blk;
  logic [31:0]       resp_data;
  logic              resp_err;

  always_comb begin
    acc_idx = idx_q;
    acc_hit = hit_q;
    acc_wr  = wr_q;
    acc_blk = blk_q;
    if (state == IDLE) begin
      acc_idx = idx_now;
      acc_hit = hit_now;
      acc_wr  = in_pwrite;
      acc_blk = blk_now;
    end
  end

  assign resp_data = (acc_hit && !acc_wr) ? mem[acc_idx] : 32'h0;
  assign resp_err  = !acc_hit || acc_blk;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      in_pready  <= 1'b0;
      in_prdata  <= 32'h0;
      in_pslverr <= 1'b0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      wr_q       <= 1'b0;
      blk_q      <= 1'b0;
      wdata_q    <= 32'h0;
      strb_q     <= 4'h0;
    end else begin
      in_pready  <= 1'b0;
      in_prdata  <= 32'h0;
      in_pslverr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx_q   <= idx_now;
            hit_q   <= hit_now;
            wr_q    <= in_pwrite;
            blk_q   <= blk_now;
            wdata_q <= in_pwdata;
            strb_q  <= in_pstrb;
            if (n_now == 4'd0) begin
              state      <= RESP;
              in_pready  <= 1'b1;
              in_prdata  <= resp_data;
              in_pslverr <= resp_err;
            end else begin
              state <= WAIT;
              cnt   <= n_now - 4'd1;
            end
          end
        end
        WAIT: begin
          if (!in_psel) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state      <= RESP;
            in_pready  <= 1'b1;
            in_prdata  <= resp_data;
            in_pslverr <= resp_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes commit at the end of RESP; an abort or reset never reaches RESP.
  always_ff @(posedge clock) begin
    if (state == RESP && wr_q && hit_q && !blk_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_sram_ws.sv
// Directed bench for apb_sram_ws: one default instance and one zero-wait-state instance.
module tb_apb_sram_ws;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  psel = '0, penable = '0, pwrite = '0;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [3:0]  pstrb [2];
  logic [2:0]  pprot [2];
  logic [1:0]  pready, pslverr, sck, ce_n;
  logic [31:0] prdata [2];
  logic [1:0]  dbg [2];
  wire  [3:0]  unused_dio0, unused_dio1;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  apb_sram_ws dut0 (
    .clock(clock), .reset_n(reset_n), .in_paddr(paddr[0]), .in_psel(psel[0]),
    .in_penable(penable[0]), .in_pwrite(pwrite[0]), .in_pprot(pprot[0]),
    .in_pwdata(pwdata[0]), .in_pstrb(pstrb[0]), .in_pready(pready[0]),
    .in_prdata(prdata[0]), .in_pslverr(pslverr[0]), .qspi_sck(sck[0]),
    .qspi_ce_n(ce_n[0]), .qspi_dio(unused_dio0), .dbg_state(dbg[0])
  );

  apb_sram_ws #(.RD_WAIT(0), .WR_WAIT(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_paddr(paddr[1]), .in_psel(psel[1]),
    .in_penable(penable[1]), .in_pwrite(pwrite[1]), .in_pprot(pprot[1]),
    .in_pwdata(pwdata[1]), .in_pstrb(pstrb[1]), .in_pready(pready[1]),
    .in_prdata(prdata[1]), .in_pslverr(pslverr[1]), .qspi_sck(sck[1]),
    .qspi_ce_n(ce_n[1]), .qspi_dio(unused_dio1), .dbg_state(dbg[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Setup phase, access phase, then wait (bounded) for pready; called just after a negedge.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic err, output int lat, output bit clean);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
    @(negedge clock);
    penable[d] = 1'b1;
    lat = 0;
    clean = 1'b1;
    rdata = 32'h0;
    err = 1'b0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (pready[d]) break;
      if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) clean = 1'b0;
    end
    rdata = prdata[d];
    err = pslverr[d];
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic do_wr(input string tag, input int d, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot, input int exp_lat, input bit exp_err);
    logic [31:0] rd; logic err; int lat; bit clean;
    xfer(d, 1'b1, addr, data, strb, prot, rd, err, lat, clean);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".rdata0"}, rd, 32'h0);
    check({tag, ".quiet"}, {31'b0, clean}, 32'd1);
  endtask

  task automatic do_rd(input string tag, input int d, input logic [31:0] addr, input int exp_lat,
                       input logic [31:0] exp_data, input bit exp_err);
    logic [31:0] rd; logic err; int lat; bit clean;
    xfer(d, 1'b0, addr, 32'h0, 4'h0, 3'b000, rd, err, lat, clean);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".data"}, rd, exp_data);
    check({tag, ".quiet"}, {31'b0, clean}, 32'd1);
  endtask

  logic [31:0] pair_data [8];
  bit quiet;

  initial begin
    pair_data = '{32'h0000_0001, 32'hFFFF_FFFF, 32'hA5A5_5A5A, 32'h1234_5678,
                  32'h8000_0000, 32'h0F0F_F0F0, 32'hCAFE_BABE, 32'h7654_3210};
    for (int d = 0; d < 2; d++) begin
      paddr[d] = 32'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0; pprot[d] = 3'b000;
    end

    // Reset state
    repeat (3) @(negedge clock);
    check("rst.pready", {30'b0, pready}, 32'd0);
    check("rst.pslverr", {30'b0, pslverr}, 32'd0);
    check("rst.prdata0", prdata[0], 32'h0);
    check("rst.state", {30'b0, dbg[0]}, {30'b0, S_IDLE});
    check("rst.sck", {30'b0, sck}, 32'd0);
    check("rst.ce_n", {30'b0, ce_n}, 32'd3);
    reset_n = 1'b1;
    @(negedge clock);
    check("rel.state", {30'b0, dbg[0]}, {30'b0, S_IDLE});

    // Default wait states: write N=1 -> pready at T0+2, read N=2 -> T0+3
    do_wr("wr_dead", 0, 32'h8000_0400, 32'hDEAD_BEEF, 4'hF, 3'b001, 2, 1'b0);
    @(negedge clock);
    check("wr_dead.pready_one", {31'b0, pready[0]}, 32'd0);
    check("wr_dead.idle", {30'b0, dbg[0]}, {30'b0, S_IDLE});
    do_rd("rd_dead", 0, 32'h8000_0400, 3, 32'hDEAD_BEEF, 1'b0);

    // Partial strobe merge
    do_wr("wr_strb5", 0, 32'h8000_0400, 32'h1122_3344, 4'h5, 3'b001, 2, 1'b0);
    do_rd("rd_strb5", 0, 32'h8000_0400, 3, 32'hDE22_BE44, 1'b0);
    do_wr("wr_strb0", 0, 32'h8000_0400, 32'h0000_0000, 4'h0, 3'b001, 2, 1'b0);
    do_rd("rd_strb0", 0, 32'h8000_0403, 3, 32'hDE22_BE44, 1'b0);

    // Miss: error with hit latency, no memory side effect
    do_wr("wr_base", 0, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 3'b001, 2, 1'b0);
    do_rd("rd_miss", 0, 32'h9000_0000, 3, 32'h0, 1'b1);
    do_wr("wr_miss", 0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 3'b001, 2, 1'b1);
    do_rd("rd_base", 0, 32'h8000_0000, 3, 32'h0BAD_F00D, 1'b0);

    // psel dropped during WAIT of a read
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 32'h8000_0400;
    @(negedge clock); penable[0] = 1'b1;
    @(negedge clock);
    check("abort_rd.wait", {30'b0, dbg[0]}, {30'b0, S_WAIT});
    psel[0] = 1'b0; penable[0] = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0 || prdata[0] !== 32'h0) quiet = 1'b0;
    end
    check("abort_rd.quiet", {31'b0, quiet}, 32'd1);
    check("abort_rd.idle", {30'b0, dbg[0]}, {30'b0, S_IDLE});

    // psel dropped during WAIT of a write: memory untouched
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h8000_0400;
    pwdata[0] = 32'h5555_5555; pstrb[0] = 4'hF; pprot[0] = 3'b001;
    @(negedge clock); penable[0] = 1'b1;
    @(negedge clock);
    psel[0] = 1'b0; penable[0] = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) quiet = 1'b0;
    end
    check("abort_wr.quiet", {31'b0, quiet}, 32'd1);
    do_rd("abort_wr.rd", 0, 32'h8000_0400, 3, 32'hDE22_BE44, 1'b0);

    // Reset during WAIT of a write discards it
    do_wr("wr_10", 0, 32'h8000_0010, 32'h1234_5678, 4'hF, 3'b001, 2, 1'b0);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h8000_0010;
    pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF;
    @(negedge clock); penable[0] = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid.state", {30'b0, dbg[0]}, {30'b0, S_IDLE});
    check("rst_mid.pready", {31'b0, pready[0]}, 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (pready[0] !== 1'b0) quiet = 1'b0;
    end
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_mid.quiet", {31'b0, quiet}, 32'd1);
    do_rd("rst_mid.rd", 0, 32'h8000_0010, 3, 32'h1234_5678, 1'b0);

    // Zero wait states: eight back-to-back write/read pairs
    for (int i = 0; i < 8; i++) begin
      do_wr($sformatf("zw_wr%0d", i), 1, 32'h8000_0100 + 32'(i * 4), pair_data[i], 4'hF, 3'b001, 1, 1'b0);
      exp_q.push_back(pair_data[i]);
      do_rd($sformatf("zw_rd%0d", i), 1, 32'h8000_0100 + 32'(i * 4), 1, exp_q.pop_front(), 1'b0);
    end

`ifdef APB_SRAM_WS_WPROT_EN
    do_wr("wp_init", 0, 32'h8000_0014, 32'h1111_1111, 4'hF, 3'b001, 2, 1'b0);
    do_wr("wp_user", 0, 32'h8000_0014, 32'h2222_2222, 4'hF, 3'b000, 2, 1'b1);
    do_rd("wp_user.rd", 0, 32'h8000_0014, 3, 32'h1111_1111, 1'b0);
    do_wr("wp_priv", 0, 32'h8000_0014, 32'h2222_2222, 4'hF, 3'b001, 2, 1'b0);
    do_rd("wp_priv.rd", 0, 32'h8000_0014, 3, 32'h2222_2222, 1'b0);
`else
    do_wr("np_user", 0, 32'h8000_0014, 32'h2222_2222, 4'hF, 3'b000, 2, 1'b0);
    do_rd("np_user.rd", 0, 32'h8000_0014, 3, 32'h2222_2222, 1'b0);
`endif

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
